// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundle of the result-producer handshake and the common data
// bus (CDB) broadcast driven by cdb_arbiter.
//   flush          : pipeline flush, discard all buffered results
//   src_valid      : per-source result-valid strobe            [NUM_SRC]
//   src_index      : per-source lock tag, source s at [s*LOCK_W +: LOCK_W]
//   src_result     : per-source result,   source s at [s*DATA_W +: DATA_W]
//   src_stall      : per-source FIFO full, producer must hold  [NUM_SRC]
//   cdb_out_valid  : broadcast present this cycle
//   cdb_out_index  : broadcast tag (NO_LOCK when idle)
//   cdb_out_result : broadcast data (0 when idle)
//   cdb_out_src    : granted source number (0 when idle)
// Modports: master = producer/consumer side, slave = arbiter side.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned LOCK_W  = 5,
    parameter int unsigned DATA_W  = 32
);
    logic                        flush;
    logic [NUM_SRC-1:0]          src_valid;
    logic [NUM_SRC*LOCK_W-1:0]   src_index;
    logic [NUM_SRC*DATA_W-1:0]   src_result;
    logic [NUM_SRC-1:0]          src_stall;
    logic                        cdb_out_valid;
    logic [LOCK_W-1:0]           cdb_out_index;
    logic [DATA_W-1:0]           cdb_out_result;
    logic [$clog2(NUM_SRC)-1:0]  cdb_out_src;

    modport master (
        output flush, src_valid, src_index, src_result,
        input  src_stall, cdb_out_valid, cdb_out_index, cdb_out_result, cdb_out_src
    );

    modport slave (
        input  flush, src_valid, src_index, src_result,
        output src_stall, cdb_out_valid, cdb_out_index, cdb_out_result, cdb_out_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers completed results from NUM_SRC functional units in
// small per-source FIFOs and grants one per cycle onto the registered common
// data bus. Tag NO_LOCK means "no broadcast" and is never stored.
// Ports:
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset (overrides flush and pushes)
//   bus : cdb_arbiter_if.slave (flush, src_* inputs, src_stall and cdb_out_*)
// Build option: define CDB_FIXED_PRIO_EN for fixed priority (lowest-numbered
// non-empty source wins, no round-robin pointer); default is round-robin.
module cdb_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned LOCK_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NO_LOCK = 0
) (
    input  logic         clk,
    input  logic         rst,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [LOCK_W-1:0] IDLE_TAG = LOCK_W'(NO_LOCK);

    logic [LOCK_W-1:0] mem_index  [NUM_SRC][DEPTH];
    logic [DATA_W-1:0] mem_result [NUM_SRC][DEPTH];
    logic [PTR_W-1:0]  rd_ptr     [NUM_SRC];
    logic [PTR_W-1:0]  wr_ptr     [NUM_SRC];
    logic [CNT_W-1:0]  count      [NUM_SRC];

    logic [NUM_SRC-1:0] stall;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               grant_any;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   cand;

    logic               out_valid;
    logic [LOCK_W-1:0]  out_index;
    logic [DATA_W-1:0]  out_result;
    logic [SRC_W-1:0]   out_src;

`ifndef CDB_FIXED_PRIO_EN
    logic [SRC_W-1:0]   rr_ptr;
`endif

    // Only FIFOs non-empty before the edge are eligible, so a same-cycle push
    // can never be granted (no bypass).
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
`ifdef CDB_FIXED_PRIO_EN
            cand = SRC_W'(k);
`else
            cand = SRC_W'((32'(rr_ptr) + k) % NUM_SRC);
`endif
            if (!grant_any && count[cand] != '0) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Stall looks at the count only; a same-cycle pop is not credited.
    always_comb begin
        stall = '0;
        push  = '0;
        pop   = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            stall[s] = (count[s] == CNT_W'(DEPTH));
            push[s]  = bus.src_valid[s]
                     && (bus.src_index[s*LOCK_W +: LOCK_W] != IDLE_TAG)
                     && !stall[s];
            pop[s]   = grant_any && (grant_idx == SRC_W'(s));
        end
    end

    // Storage needs no reset; rst/flush clear the pointers and counts instead.
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (push[s]) begin
                mem_index[s][wr_ptr[s]]  <= bus.src_index[s*LOCK_W +: LOCK_W];
                mem_result[s][wr_ptr[s]] <= bus.src_result[s*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
            out_valid  <= 1'b0;
            out_index  <= IDLE_TAG;
            out_result <= '0;
            out_src    <= '0;
        end else begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
                if (push[s] && !pop[s])
                    count[s] <= count[s] + CNT_W'(1);
                else if (!push[s] && pop[s])
                    count[s] <= count[s] - CNT_W'(1);
            end
            out_valid  <= grant_any;
            out_index  <= grant_any ? mem_index[grant_idx][rd_ptr[grant_idx]] : IDLE_TAG;
            out_result <= grant_any ? mem_result[grant_idx][rd_ptr[grant_idx]] : '0;
            out_src    <= grant_any ? grant_idx : '0;
        end
    end

`ifndef CDB_FIXED_PRIO_EN
    // Pointer survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (!bus.flush && grant_any) begin
            rr_ptr <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
        end
    end
`endif

    assign bus.src_stall      = stall;
    assign bus.cdb_out_valid  = out_valid;
    assign bus.cdb_out_index  = out_index;
    assign bus.cdb_out_result = out_result;
    assign bus.cdb_out_src    = out_src;
endmodule
